// File: rtl/frog_mover.sv
// frog_mover: player sprite position, auto-repeating moves, lives and score on a WIDTH x HEIGHT playfield.
module frog_mover #(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 8,
  parameter int HOME_X = 3,
  parameter int LIVES = 3,
  parameter int WRAP_X = 1,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE = 4,
  parameter int SCORE_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic resetGame,
  input  logic pause,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  input  logic hit,
  output logic [$clog2(WIDTH)-1:0] frogX,
  output logic [$clog2(HEIGHT)-1:0] frogY,
  output logic [WIDTH*HEIGHT-1:0] frogGrid,
  output logic [SCORE_W-1:0] score,
  output logic [$clog2(LIVES+1)-1:0] lives,
  output logic gameOver,
  output logic scored,
  output logic died
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int LW = $clog2(LIVES+1);
  localparam int GW = WIDTH * HEIGHT;
  localparam int TMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [XW-1:0] HX = XW'(HOME_X);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH-1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT-1);
  logic [3:0] btn, prev, nprev, act, nact, req;
  logic [TW-1:0] tmr [4];
  logic [TW-1:0] ntmr [4];
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [SCORE_W-1:0] nscore;
  logic [LW-1:0] nlives;
  logic ngo, nscored, ndied, run;
  assign btn = {right, left, down, up};
  assign run = !pause && !gameOver;
  assign frogGrid = GW'(1) << (int'(frogY) * WIDTH + int'(frogX));
  // index 0..3 = up, down, left, right, which is also the move priority
  always_comb begin
    nx = frogX;
    ny = frogY;
    nscore = score;
    nlives = lives;
    ngo = gameOver;
    nscored = 1'b0;
    ndied = 1'b0;
    nprev = btn;
    nact = act;
    ntmr = tmr;
    req = '0;
    for (int i = 0; i < 4; i++) begin
      req[i] = run && btn[i] && (!prev[i] || (act[i] && tmr[i] == '0));
      if (run) begin
        if (!btn[i]) nact[i] = 1'b0;
        else if (!prev[i]) begin
          nact[i] = 1'b1;
          ntmr[i] = TW'(REPEAT_DELAY-1);
        end else if (act[i]) ntmr[i] = tmr[i] == '0 ? TW'(REPEAT_RATE-1) : tmr[i] - 1'b1;
      end
    end
    if (resetGame) begin
      nx = HX;
      ny = '0;
      nscore = '0;
      nlives = LW'(LIVES);
      ngo = 1'b0;
      nprev = '0;
      nact = '0;
      ntmr = '{default: '0};
    end else if (run && hit) begin
      nx = HX;
      ny = '0;
      ndied = 1'b1;
      nlives = lives - 1'b1;
      ngo = lives == LW'(1);
    end else if (req[0]) begin
      if (frogY == YMAX) begin
        nx = HX;
        ny = '0;
        nscore = &score ? score : score + 1'b1;
        nscored = 1'b1;
      end else ny = frogY + 1'b1;
    end else if (req[1]) ny = frogY == '0 ? frogY : frogY - 1'b1;
    else if (req[2]) nx = frogX == XMAX ? (WRAP_X != 0 ? '0 : frogX) : frogX + 1'b1;
    else if (req[3]) nx = frogX == '0 ? (WRAP_X != 0 ? XMAX : frogX) : frogX - 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      frogX <= HX;
      frogY <= '0;
      score <= '0;
      lives <= LW'(LIVES);
      gameOver <= 1'b0;
      scored <= 1'b0;
      died <= 1'b0;
      prev <= '0;
      act <= '0;
      tmr <= '{default: '0};
    end else begin
      frogX <= nx;
      frogY <= ny;
      score <= nscore;
      lives <= nlives;
      gameOver <= ngo;
      scored <= nscored;
      died <= ndied;
      prev <= nprev;
      act <= nact;
      tmr <= ntmr;
    end
endmodule

// File: tb/tb_frog_mover.sv
// tb_frog_mover: wrap and saturate instances checked every cycle against a held-count reference model.
module tb_frog_mover;
  localparam int RD = 4;
  localparam int RR = 2;
  localparam bit [3:0] UP = 4'd1, DN = 4'd2, LF = 4'd4;
  logic clk = 1'b0, reset = 1'b0, resetGame = 1'b0, pause = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hit = 1'b0;
  logic [2:0] x0, y0, x1, y1;
  logic [63:0] g0, g1;
  logic [7:0] s0;
  logic [1:0] s1, l0, l1;
  logic go0, go1, sc0, sc1, di0, di1;
  always #5 clk = ~clk;
  frog_mover #(.WRAP_X(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut0 (
    .clk(clk), .reset(reset), .resetGame(resetGame), .pause(pause), .up(up), .down(down),
    .left(left), .right(right), .hit(hit), .frogX(x0), .frogY(y0), .frogGrid(g0), .score(s0),
    .lives(l0), .gameOver(go0), .scored(sc0), .died(di0));
  frog_mover #(.WRAP_X(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .SCORE_W(2)) dut1 (
    .clk(clk), .reset(reset), .resetGame(resetGame), .pause(pause), .up(up), .down(down),
    .left(left), .right(right), .hit(hit), .frogX(x1), .frogY(y1), .frogGrid(g1), .score(s1),
    .lives(l1), .gameOver(go1), .scored(sc1), .died(di1));
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [7:0] score;
    logic [1:0] lives;
    logic go;
    logic scored;
    logic died;
  } exp_t;
  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int mx[2], my[2], ms[2], ml[2];
  bit mgo[2], msc[2], mdi[2];
  bit [3:0] mprev[2], mact[2];
  int mh[2][4];
  // mh counts cycles a button has been held since its press; repeats land at RD, RD+RR, ...
  task automatic model_step(input int d, input bit rs, input bit rg, input bit pz, input bit [3:0] b, input bit ht);
    bit [3:0] req;
    bit run;
    int smax;
    smax = d == 0 ? 255 : 3;
    if (!rs || rg) begin
      mx[d] = 3; my[d] = 0; ms[d] = 0; ml[d] = 3;
      mgo[d] = 0; msc[d] = 0; mdi[d] = 0; mprev[d] = 0; mact[d] = 0;
      return;
    end
    run = !pz && !mgo[d];
    req = 0;
    msc[d] = 0;
    mdi[d] = 0;
    for (int i = 0; i < 4; i++)
      if (run) begin
        if (!b[i]) mact[d][i] = 0;
        else if (!mprev[d][i]) begin
          mact[d][i] = 1; mh[d][i] = 0; req[i] = 1;
        end else if (mact[d][i]) begin
          mh[d][i]++;
          req[i] = mh[d][i] >= RD && (mh[d][i] - RD) % RR == 0;
        end
      end
    mprev[d] = b;
    if (run && ht) begin
      mdi[d] = 1; ml[d]--; mgo[d] = ml[d] == 0; mx[d] = 3; my[d] = 0;
    end else if (req[0]) begin
      if (my[d] == 7) begin
        mx[d] = 3; my[d] = 0; ms[d] = ms[d] < smax ? ms[d] + 1 : smax; msc[d] = 1;
      end else my[d]++;
    end else if (req[1]) begin
      if (my[d] > 0) my[d]--;
    end else if (req[2]) mx[d] = mx[d] == 7 ? (d == 0 ? 0 : 7) : mx[d] + 1;
    else if (req[3]) mx[d] = mx[d] == 0 ? (d == 0 ? 7 : 0) : mx[d] - 1;
  endtask
  function automatic exp_t expect_of(input int d);
    exp_t e;
    e.x = 3'(mx[d]); e.y = 3'(my[d]); e.score = 8'(ms[d]); e.lives = 2'(ml[d]);
    e.go = mgo[d]; e.scored = msc[d]; e.died = mdi[d];
    return e;
  endfunction
  task automatic chk(input int d, input exp_t e, input exp_t g, input logic [63:0] grid);
    logic [63:0] eg;
    eg = 64'd1 << (int'(e.y) * 8 + int'(e.x));
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL state dut%0d t=%0t: got x=%0d y=%0d score=%0d lives=%0d go=%0b scored=%0b died=%0b, want x=%0d y=%0d score=%0d lives=%0d go=%0b scored=%0b died=%0b",
        d, $time, g.x, g.y, g.score, g.lives, g.go, g.scored, g.died, e.x, e.y, e.score, e.lives, e.go, e.scored, e.died);
    end
    checks++;
    if (grid !== eg) begin
      errors++;
      $display("FAIL grid dut%0d t=%0t: got %h want %h", d, $time, grid, eg);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) chk(0, q0.pop_front(), {x0, y0, s0, l0, go0, sc0, di0}, g0);
    if (q1.size() > 0) chk(1, q1.pop_front(), {x1, y1, 6'd0, s1, l1, go1, sc1, di1}, g1);
  end
  task automatic step(input bit rs, input bit rg, input bit pz, input bit [3:0] b, input bit ht);
    @(negedge clk);
    reset = rs; resetGame = rg; pause = pz; {right, left, down, up} = b; hit = ht;
    for (int d = 0; d < 2; d++) model_step(d, rs, rg, pz, b, ht);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask
  task automatic hold(input bit [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, b, 0);
    step(1, 0, 0, 0, 0);
  endtask
  initial begin
    bit [3:0] b;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle(2);
    hold(LF, 3);
    for (int i = 0; i < 4; i++) hold(LF, 1);
    hold(DN, 1);
    hold(UP, 10);
    for (int i = 0; i < 36; i++) hold(UP, 1);
    hold(UP | LF, 1);
    hold(UP | DN | LF | 4'd8, 2);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1);
      idle(2);
    end
    hold(UP, 6);
    hold(LF, 2);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    idle(1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, UP, 0);
    step(1, 0, 0, UP, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, UP, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, UP, 0);
    hold(UP, 6);
    for (int i = 0; i < 6; i++) step(1, 0, 0, UP, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({x0, y0, s0, l0, go0, sc0, di0, x1, y1, s1, l1} !== {3'd3, 3'd0, 8'd0, 2'd3, 3'd0, 3'd3, 3'd0, 2'd0, 2'd3}) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d score=%0d lives=%0d go=%0b, want x=3 y=0 score=0 lives=3 go=0",
        x0, y0, s0, l0, go0);
    end
    for (int d = 0; d < 2; d++) model_step(d, 0, 0, 0, 0, 0);
    step(0, 0, 0, UP, 0);
    step(0, 0, 0, 0, 0);
    idle(3);
    hold(UP, 1);
    b = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) b[i] = ~b[i];
      step(1, $urandom_range(99) == 0, $urandom_range(9) == 0, b, $urandom_range(59) == 0);
    end
    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
